// File: rtl/blackjack_round_ctrl.sv
// BlackJack round sequencer: button sync, card req/ack handshake, hands, dealer policy.
// Optional soft-ace scoring is enabled by defining ACE_SOFT_EN.
module blackjack_round_ctrl #(
    parameter int CARD_W       = 4,
    parameter int HAND_W       = 5,
    parameter int DEALER_STAND = 17,
    parameter int BJ_LIMIT     = 21
) (
    input  logic              Clock,
    input  logic              reset,
    input  logic              enter_n,
    input  logic              pass_n,
    output logic              card_req,
    input  logic              card_ack,
    input  logic [CARD_W-1:0] card_val,
    output logic [HAND_W-1:0] phand,
    output logic [HAND_W-1:0] dhand,
    output logic [3:0]        state_out,
    output logic              win,
    output logic              lose
);

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_DP1   = 4'd1,
        S_DD1   = 4'd2,
        S_DP2   = 4'd3,
        S_PLAY  = 4'd4,
        S_PDRAW = 4'd5,
        S_DDRAW = 4'd6,
        S_DCHK  = 4'd7,
        S_WIN   = 4'd8,
        S_LOSE  = 4'd9
    } state_t;

    localparam int SW = HAND_W + 2;
    localparam logic [SW-1:0] LIM     = SW'(BJ_LIMIT);
    localparam logic [SW-1:0] SUM_MAX = SW'((2 ** HAND_W) - 1);
    localparam logic [HAND_W-1:0] H_LIM   = HAND_W'(BJ_LIMIT);
    localparam logic [HAND_W-1:0] H_STAND = HAND_W'(DEALER_STAND);

    function automatic logic [CARD_W-1:0] clamp_card(input logic [CARD_W-1:0] raw);
        logic [CARD_W-1:0] c;
        c = raw;
        if (raw == '0) c = CARD_W'(1);
        else if (raw > CARD_W'(10)) c = CARD_W'(10);
        return c;
    endfunction

`ifdef ACE_SOFT_EN
    // Returns {soft, sum}; a soft ace is demoted to 1 before the hand busts.
    function automatic logic [HAND_W:0] add_card(input logic [HAND_W-1:0] sum,
                                                 input logic soft,
                                                 input logic [CARD_W-1:0] raw);
        logic [CARD_W-1:0] c;
        logic [SW-1:0]     s;
        logic              soft_o;
        c      = clamp_card(raw);
        s      = SW'(sum) + SW'(c);
        soft_o = soft;
        if (c == CARD_W'(1) && (SW'(sum) + SW'(11)) <= LIM) begin
            s      = SW'(sum) + SW'(11);
            soft_o = 1'b1;
        end else if (s > LIM && soft) begin
            s      = s - SW'(10);
            soft_o = 1'b0;
        end
        if (s > SUM_MAX) s = SUM_MAX;
        return {soft_o, s[HAND_W-1:0]};
    endfunction
`else
    function automatic logic [HAND_W-1:0] add_card(input logic [HAND_W-1:0] sum,
                                                   input logic [CARD_W-1:0] raw);
        logic [SW-1:0] s;
        s = SW'(sum) + SW'(clamp_card(raw));
        if (s > SUM_MAX) s = SUM_MAX;
        return s[HAND_W-1:0];
    endfunction
`endif

    logic [2:0]        en_sync_q, ps_sync_q;
    state_t            state_q, state_d;
    logic [HAND_W-1:0] phand_q, phand_d, dhand_q, dhand_d;
    logic              card_req_q, card_req_d;
    logic              win_q, win_d, lose_q, lose_d;
    logic              enter_p, pass_p, got;
`ifdef ACE_SOFT_EN
    logic              psoft_q, psoft_d, dsoft_q, dsoft_d;
`endif

    // Buttons idle high; a pulse fires one cycle after the synchronized fall.
    assign enter_p = en_sync_q[2] & ~en_sync_q[1];
    assign pass_p  = ps_sync_q[2] & ~ps_sync_q[1];
    assign got     = card_req_q & card_ack;

    always_ff @(posedge Clock or posedge reset) begin
        if (reset) begin
            en_sync_q  <= 3'b111;
            ps_sync_q  <= 3'b111;
            state_q    <= S_IDLE;
            phand_q    <= '0;
            dhand_q    <= '0;
            card_req_q <= 1'b0;
            win_q      <= 1'b0;
            lose_q     <= 1'b0;
`ifdef ACE_SOFT_EN
            psoft_q    <= 1'b0;
            dsoft_q    <= 1'b0;
`endif
        end else begin
            en_sync_q  <= {en_sync_q[1:0], enter_n};
            ps_sync_q  <= {ps_sync_q[1:0], pass_n};
            state_q    <= state_d;
            phand_q    <= phand_d;
            dhand_q    <= dhand_d;
            card_req_q <= card_req_d;
            win_q      <= win_d;
            lose_q     <= lose_d;
`ifdef ACE_SOFT_EN
            psoft_q    <= psoft_d;
            dsoft_q    <= dsoft_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        phand_d    = phand_q;
        dhand_d    = dhand_q;
        card_req_d = 1'b0;
`ifdef ACE_SOFT_EN
        psoft_d    = psoft_q;
        dsoft_d    = dsoft_q;
`endif
        case (state_q)
            S_IDLE, S_WIN, S_LOSE: begin
                if (enter_p) begin
                    phand_d = '0;
                    dhand_d = '0;
`ifdef ACE_SOFT_EN
                    psoft_d = 1'b0;
                    dsoft_d = 1'b0;
`endif
                    state_d = S_DP1;
                end
            end
            S_DP1, S_DP2, S_PDRAW: begin
                if (got) begin
`ifdef ACE_SOFT_EN
                    {psoft_d, phand_d} = add_card(phand_q, psoft_q, card_val);
`else
                    phand_d = add_card(phand_q, card_val);
`endif
                    state_d = (state_q == S_DP1) ? S_DD1 : S_PLAY;
                end else begin
                    card_req_d = 1'b1;
                end
            end
            S_DD1, S_DDRAW: begin
                if (got) begin
`ifdef ACE_SOFT_EN
                    {dsoft_d, dhand_d} = add_card(dhand_q, dsoft_q, card_val);
`else
                    dhand_d = add_card(dhand_q, card_val);
`endif
                    state_d = (state_q == S_DD1) ? S_DP2 : S_DCHK;
                end else begin
                    card_req_d = 1'b1;
                end
            end
            S_PLAY: begin
                if (phand_q == H_LIM)     state_d = S_WIN;
                else if (phand_q > H_LIM) state_d = S_LOSE;
                else if (enter_p)         state_d = S_PDRAW;
                else if (pass_p)          state_d = S_DDRAW;
            end
            S_DCHK: begin
                if (dhand_q > H_LIM)           state_d = S_WIN;
                else if (dhand_q < H_STAND)    state_d = S_DDRAW;
                else if (dhand_q > phand_q)    state_d = S_LOSE;
                else                           state_d = S_WIN;
            end
            default: state_d = S_IDLE;
        endcase
        win_d  = (state_d == S_WIN);
        lose_d = (state_d == S_LOSE);
    end

    assign card_req  = card_req_q;
    assign phand     = phand_q;
    assign dhand     = dhand_q;
    assign state_out = state_q;
    assign win       = win_q;
    assign lose      = lose_q;

endmodule
